// File: rtl/hba_pkg.sv
// ----------------------------------------------------------------------------
// hba_pkg : shared HBA widths, peripheral slot numbers, arbiter state encoding
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hba_pkg;

  localparam int DEF_NUM_MASTERS       = 2;
  localparam int DEF_DBUS_WIDTH        = 8;
  localparam int DEF_PERIPH_ADDR_WIDTH = 4;
  localparam int DEF_REG_ADDR_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH        = DEF_PERIPH_ADDR_WIDTH + DEF_REG_ADDR_WIDTH;
  localparam int DEF_TIMEOUT_CYCLES    = 255;

  localparam logic [DEF_PERIPH_ADDR_WIDTH-1:0] SLOT_TBC     = 4'd0;
  localparam logic [DEF_PERIPH_ADDR_WIDTH-1:0] SLOT_BASICIO = 4'd1;
  localparam logic [DEF_PERIPH_ADDR_WIDTH-1:0] SLOT_QTR     = 4'd2;
  localparam logic [DEF_PERIPH_ADDR_WIDTH-1:0] SLOT_MOTOR   = 4'd3;
  localparam logic [DEF_PERIPH_ADDR_WIDTH-1:0] SLOT_SONAR   = 4'd4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  // Index width that stays legal for a single-master build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hba_master_arbiter_if.sv
// ----------------------------------------------------------------------------
// hba_master_arbiter_if : master-facing and slave-facing HBA bus signals
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hba_master_arbiter_if
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int DBUS_WIDTH  = DEF_DBUS_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
);

  logic [NUM_MASTERS-1:0]            m_mrequest;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_abus;
  logic [NUM_MASTERS-1:0]            m_rnw;
  logic [NUM_MASTERS-1:0]            m_select;
  logic [NUM_MASTERS*DBUS_WIDTH-1:0] m_dbus;
  logic [NUM_MASTERS-1:0]            m_mgrant;
  logic                              m_xferack;
  logic [DBUS_WIDTH-1:0]             m_dbus_rd;

  logic [ADDR_WIDTH-1:0]             hba_abus;
  logic                              hba_rnw;
  logic                              hba_select;
  logic [DBUS_WIDTH-1:0]             hba_dbus_wr;
  logic                              hba_xferack;
  logic [DBUS_WIDTH-1:0]             hba_dbus;

  // The arbiter is the slave of the requesting masters and drives the shared bus.
  modport slave (
    input  m_mrequest, m_abus, m_rnw, m_select, m_dbus, hba_xferack, hba_dbus,
    output m_mgrant, m_xferack, m_dbus_rd, hba_abus, hba_rnw, hba_select, hba_dbus_wr
  );

  modport master (
    output m_mrequest, m_abus, m_rnw, m_select, m_dbus, hba_xferack, hba_dbus,
    input  m_mgrant, m_xferack, m_dbus_rd, hba_abus, hba_rnw, hba_select, hba_dbus_wr
  );

endinterface

`default_nettype wire

// File: rtl/hba_rr_pick.sv
// ----------------------------------------------------------------------------
// hba_rr_pick : combinational round-robin picker, first requester from ptr up
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hba_rr_pick
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int IDX_WIDTH   = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_WIDTH-1:0]   ptr,
  output logic [NUM_MASTERS-1:0] grant_oh,
  output logic [IDX_WIDTH-1:0]   grant_idx,
  output logic                   valid
);

  logic [NUM_MASTERS-1:0] rot;
  int                     sum;

  always_comb begin
    // rot[k] is the request of master (ptr+k) mod NUM_MASTERS.
    rot       = NUM_MASTERS'({req, req} >> ptr);
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    sum       = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= NUM_MASTERS) begin
          sum = sum - NUM_MASTERS;
        end
        grant_idx = IDX_WIDTH'(sum);
        grant_oh  = NUM_MASTERS'(1) << sum;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hba_master_arbiter.sv
// ----------------------------------------------------------------------------
// hba_master_arbiter : round-robin HBA bus arbiter/mux with slave timeout ack
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hba_master_arbiter
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS       = DEF_NUM_MASTERS,
  parameter int DBUS_WIDTH        = DEF_DBUS_WIDTH,
  parameter int PERIPH_ADDR_WIDTH = DEF_PERIPH_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH    = DEF_REG_ADDR_WIDTH,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                 hba_clk,
  input  logic                 hba_reset_n,
  hba_master_arbiter_if.slave  bus,
  output logic                 timeout_err
);

  localparam int              IDX_WIDTH = idx_width(NUM_MASTERS);
  localparam logic [7:0]      TMO_MAX   = 8'(TIMEOUT_CYCLES);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]             tmo_cnt_q, tmo_cnt_d;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_WIDTH-1:0]   pick_idx;
  logic                   pick_valid;

  logic                   any_grant;
  logic [ADDR_WIDTH-1:0]  mux_abus;
  logic                   mux_rnw;
  logic                   mux_select;
  logic [DBUS_WIDTH-1:0]  mux_dbus;
  logic                   timeout_hit;

  hba_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_rr_pick (
    .req       (bus.m_mrequest),
    .ptr       (rr_ptr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .valid     (pick_valid)
  );

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_oh;
          idx_d   = pick_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // Only the owner's request matters; others wait for the next IDLE.
        if (!(|(bus.m_mrequest & grant_q))) begin
          grant_d  = '0;
          rr_ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d  = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    mux_abus   = '0;
    mux_rnw    = 1'b0;
    mux_select = 1'b0;
    mux_dbus   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        mux_abus   = mux_abus   | bus.m_abus[i*ADDR_WIDTH +: ADDR_WIDTH];
        mux_rnw    = mux_rnw    | bus.m_rnw[i];
        mux_select = mux_select | bus.m_select[i];
        mux_dbus   = mux_dbus   | bus.m_dbus[i*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end
  end

  assign any_grant       = |grant_q;
  assign bus.m_mgrant    = grant_q;
  assign bus.hba_abus    = mux_abus;
  assign bus.hba_rnw     = mux_rnw;
  assign bus.hba_select  = mux_select;
  assign bus.hba_dbus_wr = mux_dbus;

  // A real slave ack in the timeout cycle wins over the forced ack.
  assign timeout_hit = mux_select && !bus.hba_xferack && (tmo_cnt_q == TMO_MAX);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 8'd1;
    if (!mux_select || bus.hba_xferack || timeout_hit) begin
      tmo_cnt_d = '0;
    end
  end

  assign bus.m_xferack = any_grant && (bus.hba_xferack || timeout_hit);
  assign bus.m_dbus_rd = (any_grant && !timeout_hit) ? bus.hba_dbus : '0;
  assign timeout_err   = timeout_hit;

endmodule

`default_nettype wire
